// File: rtl/switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : switch_debouncer
// Brief    : Two-flop synchroniser followed by a four-state confirmation FSM
//            that turns a bouncy mechanical contact into a clean relay-coil
//            level, with one-cycle rise/fall pulses and a toggle counter.
// Revision : 1.0  initial release
// ============================================================================
module switch_debouncer #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             raw_switch,
  input  logic             enable,
  output logic             switch_out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             bouncing,
  output logic [CNT_W-1:0] toggle_count
);

  // Stable counter is 8 bits wide: enough for the largest legal STABLE_CYCLES.
  localparam logic [7:0]       c_LAST_CNT = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0]       c_CNT_ONE  = 8'd1;
  localparam logic [CNT_W-1:0] c_TGL_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE_LOW     = 2'd0,
    CONFIRM_HIGH = 2'd1,
    IDLE_HIGH    = 2'd2,
    CONFIRM_LOW  = 2'd3
  } state_t;

  logic             sync1_q;
  logic             sync2_q;
  state_t           state_q,  state_d;
  logic [7:0]       cnt_q,    cnt_d;
  logic             level_q,  level_d;
  logic             rise_q,   rise_d;
  logic             fall_q,   fall_d;
  logic             busy_q,   busy_d;
  logic [CNT_W-1:0] tgl_q,    tgl_d;

  // Two-flop synchroniser; keeps running regardless of enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_switch;
      sync2_q <= sync1_q;
    end
  end

  // Next-state logic: a change must be seen on STABLE_CYCLES consecutive
  // enabled samples; any contrary sample or a disable aborts to idle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    tgl_d   = tgl_q;
    unique case (state_q)
      IDLE_LOW: begin
        if (enable && sync2_q) begin
          state_d = CONFIRM_HIGH;
          cnt_d   = c_CNT_ONE;
        end
      end
      CONFIRM_HIGH: begin
        if (!sync2_q || !enable) begin
          state_d = IDLE_LOW;
          cnt_d   = 8'd0;
        end else if (cnt_q == c_LAST_CNT) begin
          state_d = IDLE_HIGH;
          cnt_d   = 8'd0;
          level_d = 1'b1;
          rise_d  = 1'b1;
          tgl_d   = tgl_q + c_TGL_ONE;
        end else begin
          cnt_d   = cnt_q + c_CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        if (enable && !sync2_q) begin
          state_d = CONFIRM_LOW;
          cnt_d   = c_CNT_ONE;
        end
      end
      CONFIRM_LOW: begin
        if (sync2_q || !enable) begin
          state_d = IDLE_HIGH;
          cnt_d   = 8'd0;
        end else if (cnt_q == c_LAST_CNT) begin
          state_d = IDLE_LOW;
          cnt_d   = 8'd0;
          level_d = 1'b0;
          fall_d  = 1'b1;
          tgl_d   = tgl_q + c_TGL_ONE;
        end else begin
          cnt_d   = cnt_q + c_CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = 8'd0;
      end
    endcase
    busy_d = (state_d == CONFIRM_HIGH) || (state_d == CONFIRM_LOW);
  end

  // State and registered outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE_LOW;
      cnt_q   <= 8'd0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
      tgl_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
      tgl_q   <= tgl_d;
    end
  end

  assign switch_out   = level_q;
  assign rise_pulse   = rise_q;
  assign fall_pulse   = fall_q;
  assign bouncing     = busy_q;
  assign toggle_count = tgl_q;

endmodule
`default_nettype wire
